// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM word bridge and the QPI byte-stream controller.
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_W_STREAM = 3'd2,
    ST_W_END    = 3'd3,
    ST_R_STREAM = 3'd4,
    ST_R_END    = 3'd5
  } bridge_state_t;

  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] QPI_CMD_WRITE     = 8'h38;
  localparam logic [7:0] QPI_CMD_FAST_READ = 8'hEB;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/psram_edge_det.sv
// Registered single-bit edge detector; FALLING selects which edge produces the pulse.
module psram_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     prev <= 1'b0;
    else if (clr) prev <= 1'b0;
    else          prev <= din;
  end

  assign pulse = FALLING ? (prev & ~din) : (din & ~prev);

endmodule

// File: rtl/psram_word_bridge.sv
// Splits single 32-bit bus reads/writes into the PSRAM controller's byte handshake.
// state       | meaning
// IDLE        | ready for a bus request
// WAIT_MEM    | request latched, waiting for controller idle
// W_STREAM    | feeding write bytes, one per ready_for_next_byte fall
// W_END       | mem_wend held until controller idle
// R_STREAM    | capturing read bytes, one per byte_available rise
// R_END       | mem_rend held until controller idle, then spo loads
module psram_word_bridge
  import psram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] a,
  input  logic [31:0] d,
  input  logic        rd,
  input  logic        we,
  output logic [31:0] spo,
  output logic        ready,
  output logic        err,
  output logic [23:0] mem_a,
  output logic        mem_rd,
  output logic        mem_rend,
  output logic        mem_we,
  output logic        mem_wend,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_byte_available,
  input  logic        mem_ready_for_next_byte,
  input  logic        mem_ready
);

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST = 3'(BYTES_PER_WORD - 1);

  bridge_state_t state, state_nxt;

  logic [23:0]     a_q;
  logic [31:0]     d_q;
  logic [31:0]     rdata;
  logic [2:0]      idx;
  logic [TO_W-1:0] to_cnt;
  logic            is_wr, issue_q, to_flag;
  logic            issue, streaming, timeout, w_step, r_step, byte_fall, byte_rise;

  assign issue     = (state == ST_WAIT_MEM) && mem_ready;
  assign streaming = (state == ST_W_STREAM) || (state == ST_R_STREAM);
  assign timeout   = streaming && (to_cnt == TO_LAST);
  assign w_step    = (state == ST_W_STREAM) && byte_fall;
  assign r_step    = (state == ST_R_STREAM) && byte_rise;

  psram_edge_det #(.FALLING(1'b1)) u_rfnb_det (
    .clk   (clk),
    .rst   (rst),
    .clr   (issue),
    .din   (mem_ready_for_next_byte),
    .pulse (byte_fall)
  );

  psram_edge_det #(.FALLING(1'b0)) u_ba_det (
    .clk   (clk),
    .rst   (rst),
    .clr   (issue),
    .din   (mem_byte_available),
    .pulse (byte_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (we || rd) state_nxt = ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_ready) state_nxt = is_wr ? ST_W_STREAM : ST_R_STREAM;
      ST_W_STREAM: if (timeout || (w_step && idx == IDX_LAST)) state_nxt = ST_W_END;
      ST_W_END:    if (mem_ready) state_nxt = ST_IDLE;
      ST_R_STREAM: if (timeout || (r_step && idx == IDX_LAST)) state_nxt = ST_R_END;
      ST_R_END:    if (mem_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    mem_we    = (state == ST_W_STREAM) && issue_q;
    mem_rd    = (state == ST_R_STREAM) && issue_q;
    mem_wend  = (state == ST_W_END);
    mem_rend  = (state == ST_R_END);
    mem_a     = a_q & 24'hFF_FFFC;
    mem_wdata = 8'h00;
    if ((state == ST_W_STREAM) || (state == ST_W_END))
      mem_wdata = word_byte(d_q, idx[2] ? 2'd3 : idx[1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      d_q     <= '0;
      rdata   <= '0;
      spo     <= '0;
      idx     <= '0;
      to_cnt  <= '0;
      is_wr   <= 1'b0;
      issue_q <= 1'b0;
      to_flag <= 1'b0;
      err     <= 1'b0;
    end else begin
      issue_q <= issue;
      if (ready && (we || rd)) begin
        a_q   <= a;
        d_q   <= d;
        is_wr <= we;
      end
      if (issue) begin
        idx     <= '0;
        to_cnt  <= '0;
        to_flag <= 1'b0;
      end else begin
        if (streaming) to_cnt <= to_cnt + TO_W'(1);
        if (timeout) begin
          err     <= 1'b1;
          to_flag <= 1'b1;
        end
        if (w_step || r_step) idx <= idx + 3'd1;
      end
      if (r_step) rdata[{idx[1:0], 3'b000} +: 8] <= mem_rdata;
      // a timed-out read leaves the previous word visible
      if ((state == ST_R_END) && mem_ready && !to_flag) spo <= rdata;
    end
  end

endmodule
